add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning operand and sum width; only 32 is supported.
REQ-002 The block SHALL have parameter RR_INIT, default 1, meaning the reset value of the last-served pointer (1 means requester 0 wins first).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports clock (input, 1, rising-edge clock) and clear (input, 1, synchronous active-high reset).
REQ-004 The block SHALL have port req0 (input, 1): requester 0 operation request.
REQ-005 The block SHALL have ports a0 and b0 (input, W each) and cin0 (input, 1): requester 0 operands and carry-in.
REQ-006 The block SHALL have port req1 (input, 1), ports a1 and b1 (input, W each) and cin1 (input, 1): requester 1 request, operands and carry-in.
REQ-007 The block SHALL have ports gnt0 and gnt1 (output, 1 each): one-cycle grant pulses.
REQ-008 The block SHALL have ports done0 and done1 (output, 1 each): one-cycle result-valid pulses.
REQ-009 The block SHALL have ports sum_out (output, W) and cout_out (output, 1): the registered result.
REQ-010 The block SHALL have ports add_a and add_b (output, W each) and add_cin (output, 1): operands driven to the external shared 32-bit ripple adder.
REQ-011 The block SHALL have ports add_sum (input, W) and add_cout (input, 1): the shared adder's result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-013 In IDLE with any req high, the block SHALL select one requester, latch its a, b and cin into operand registers, record the winner, and go to EXEC.
REQ-014 Arbitration SHALL be round-robin: with only one req high, that requester wins; with both high, the requester other than the last-served one wins.
REQ-015 The last-served pointer SHALL update when a requester is selected.
REQ-016 In EXEC, the block SHALL assert the winner's gnt for exactly one cycle.
REQ-017 In EXEC, add_a, add_b and add_cin SHALL be driven from the operand registers.
REQ-018 At the end of EXEC, add_sum and add_cout SHALL be captured into sum_out and cout_out, and the FSM SHALL go to RESP.
REQ-019 In RESP, the block SHALL assert the winner's done for exactly one cycle and then return to IDLE.
REQ-020 Latency SHALL be fixed: req sampled at edge N gives gnt high in cycle N+1 and done high in cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-021 req0 and req1 SHALL be sampled only in IDLE; req and operand changes during EXEC or RESP SHALL have no effect.
REQ-022 A req still high when the FSM returns to IDLE SHALL start a new transaction.
REQ-023 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.
REQ-024 sum_out and cout_out SHALL hold their value until the next capture.
REQ-025 In IDLE and RESP, add_a, add_b and add_cin SHALL still be driven from the operand registers, and the adder result SHALL be ignored.
REQ-026 Arithmetic SHALL be modulo 2^W, with the carry out reported only on cout_out; no internal addition SHALL be performed.

Reset
REQ-027 While clear is high at a clock edge, the FSM SHALL go to IDLE and the pointer SHALL load RR_INIT.
REQ-028 While clear is high at a clock edge, the operand registers, sum_out, cout_out, gnt0/gnt1, done0/done1 and all add_* outputs SHALL be set to 0.
REQ-029 A clear asserted during EXEC or RESP SHALL abort the transaction with no done pulse, and the aborted requester SHALL re-request.
REQ-030 In the first cycle after clear deasserts, req SHALL be sampled normally.

Configuration
REQ-031 With macro ADD_ARB_OVF_EN defined, the block SHALL add output ovf_out (1 bit), set to 0 on reset.
REQ-032 With ADD_ARB_OVF_EN defined, ovf_out SHALL be captured at the end of EXEC as the signed overflow (a[31]==b[31]) && (add_sum[31]!=a[31]) and held like sum_out.
REQ-033 Without ADD_ARB_OVF_EN, the ovf_out port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL check: req0=1, a0=5, b0=7, cin0=0 -> gnt0 one cycle later, done0 two cycles later, sum_out=12, cout_out=0.
REQ-035 The bench SHALL check: req1=1, a1=32'hFFFFFFFF, b1=1, cin1=0 -> done1, sum_out=0, cout_out=1; with the macro, ovf_out=0.
REQ-036 The bench SHALL check: req0 and req1 both held high for 4 transactions after reset -> grant order 0,1,0,1, no overlapping gnt or done.
REQ-037 The bench SHALL check: clear pulsed in the cycle gnt0 is high -> no done0, all outputs 0 next cycle, and req0 re-served 2 cycles after clear drops.
REQ-038 The bench SHALL check: with the macro, a0=32'h7FFFFFFF, b0=1 -> sum_out=32'h80000000 and ovf_out=1.
REQ-039 The bench SHALL check: a0 changed during EXEC -> sum_out reflects the operands latched in IDLE.

Source files
------------

// File: rtl/add_arbiter.sv
// Two-requester round-robin front end for a shared external 32-bit adder.
// Optional signed-overflow output is enabled by defining ADD_ARB_OVF_EN.
module add_arbiter #(
    parameter int W       = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         cin0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         cin1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] sum_out,
    output logic         cout_out,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout
`ifdef ADD_ARB_OVF_EN
    ,
    output logic         ovf_out
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       r_state;
    logic         r_last;
    logic         r_win;
    logic [W-1:0] r_opA;
    logic [W-1:0] r_opB;
    logic         r_opCin;
    logic         r_gnt0;
    logic         r_gnt1;
    logic         r_done0;
    logic         r_done1;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         w_pick1;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
            r_last  <= RR_INIT;
            r_win   <= 1'b0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_opCin <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 | req1) begin
                        r_opA   <= w_pick1 ? a1 : a0;
                        r_opB   <= w_pick1 ? b1 : b0;
                        r_opCin <= w_pick1 ? cin1 : cin0;
                        r_win   <= w_pick1;
                        r_last  <= w_pick1;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_sum   <= add_sum;
                    r_cout  <= add_cout;
                    r_done0 <= ~r_win;
                    r_done1 <= r_win;
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADD_ARB_OVF_EN
    logic r_ovf;

    // Signed overflow: like-signed operands producing a result of the other sign.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_ovf <= 1'b0;
        end else if (r_state == EXEC) begin
            r_ovf <= (r_opA[W-1] == r_opB[W-1]) && (add_sum[W-1] != r_opA[W-1]);
        end
    end

    assign ovf_out = r_ovf;
`endif

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign sum_out  = r_sum;
    assign cout_out = r_cout;
    assign add_a    = r_opA;
    assign add_b    = r_opB;
    assign add_cin  = r_opCin;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter; models the external adder.
// Define ADD_ARB_OVF_EN to also exercise the overflow output.
module tb_add_arbiter;

    logic        clock;
    logic        clear;
    logic        req0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        cin0;
    logic        req1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        cin1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] sum_out;
    logic        cout_out;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
`ifdef ADD_ARB_OVF_EN
    logic        ovf_out;
`endif

    int checks;
    int failures;

    add_arbiter #(.W(32), .RR_INIT(1'b1)) dut (
        .clock    (clock),
        .clear    (clear),
        .req0     (req0),
        .a0       (a0),
        .b0       (b0),
        .cin0     (cin0),
        .req1     (req1),
        .a1       (a1),
        .b1       (b1),
        .cin1     (cin1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
`ifdef ADD_ARB_OVF_EN
        ,
        .ovf_out  (ovf_out)
`endif
    );

    // Shared ripple adder living outside the arbiter.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step();
        step();
        checks++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_pulses got=%b exp=0000", {gnt0, gnt1, done0, done1});
        end
        checks++;
        if ({sum_out, cout_out} !== 33'h0) begin
            failures++;
            $display("[TB] FAIL reset_result got=%h exp=0", {sum_out, cout_out});
        end
        checks++;
        if ({add_a, add_b, add_cin} !== 65'h0) begin
            failures++;
            $display("[TB] FAIL reset_add got=%h exp=0", {add_a, add_b, add_cin});
        end
`ifdef ADD_ARB_OVF_EN
        checks++;
        if (ovf_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_out);
        end
`endif
    endtask

    task automatic test_basic();
        clear = 1'b0;
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; cin0 = 1'b0;
        step();
        checks++;
        if ({gnt0, gnt1, done0} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL basic_gnt got=%b exp=100", {gnt0, gnt1, done0});
        end
        checks++;
        if (add_a !== 32'd5) begin
            failures++;
            $display("[TB] FAIL basic_add_a got=%h exp=5", add_a);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({gnt0, done0, done1} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL basic_done got=%b exp=010", {gnt0, done0, done1});
        end
        checks++;
        if ({sum_out, cout_out} !== {32'd12, 1'b0}) begin
            failures++;
            $display("[TB] FAIL basic_sum got=%h/%b exp=c/0", sum_out, cout_out);
        end
        step();
        checks++;
        if (done0 !== 1'b0 || sum_out !== 32'd12) begin
            failures++;
            $display("[TB] FAIL basic_hold got=%b/%h exp=0/c", done0, sum_out);
        end
    endtask

    task automatic test_carry();
        req1 = 1'b1; a1 = 32'hFFFFFFFF; b1 = 32'd1; cin1 = 1'b0;
        step();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL carry_gnt got=%b exp=01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        step();
        checks++;
        if ({done0, done1} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL carry_done got=%b exp=01", {done0, done1});
        end
        checks++;
        if ({sum_out, cout_out} !== {32'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL carry_sum got=%h/%b exp=0/1", sum_out, cout_out);
        end
`ifdef ADD_ARB_OVF_EN
        checks++;
        if (ovf_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL carry_ovf got=%b exp=0", ovf_out);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        int grants;
        logic [3:0] order;
        logic [3:0] expOrder;
        grants = 0;
        order = 4'b0;
        expOrder = 4'b1010;
        clear = 1'b1;
        step();
        clear = 1'b0;
        req0 = 1'b1; a0 = 32'd10;  b0 = 32'd20;  cin0 = 1'b0;
        req1 = 1'b1; a1 = 32'd100; b1 = 32'd200; cin1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if ((gnt0 & gnt1) !== 1'b0 || (done0 & done1) !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_overlap cyc=%0d got=%b exp=no overlap", k, {gnt0, gnt1, done0, done1});
            end
            if (gnt0 | gnt1) begin
                if (grants < 4) order[grants] = gnt1;
                grants++;
            end
            if (done0) begin
                checks++;
                if (sum_out !== 32'd30) begin
                    failures++;
                    $display("[TB] FAIL b2b_sum0 got=%0d exp=30", sum_out);
                end
            end
            if (done1) begin
                checks++;
                if (sum_out !== 32'd301) begin
                    failures++;
                    $display("[TB] FAIL b2b_sum1 got=%0d exp=301", sum_out);
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (grants !== 4) begin
            failures++;
            $display("[TB] FAIL b2b_count got=%0d exp=4", grants);
        end
        checks++;
        if (order !== expOrder) begin
            failures++;
            $display("[TB] FAIL b2b_order got=%b exp=%b (bit i = winner of grant i)", order, expOrder);
        end
        step();
    endtask

    task automatic test_clear_abort();
        req0 = 1'b1; a0 = 32'd3; b0 = 32'd4; cin0 = 1'b0;
        step();
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_gnt got=%b exp=1", gnt0);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({gnt0, gnt1, done0, done1, cout_out, add_cin} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL abort_flags got=%b exp=000000", {gnt0, gnt1, done0, done1, cout_out, add_cin});
        end
        checks++;
        if ({sum_out, add_a, add_b} !== 96'h0) begin
            failures++;
            $display("[TB] FAIL abort_data got=%h exp=0", {sum_out, add_a, add_b});
        end
        step();
        checks++;
        if ({gnt0, done0} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL abort_regnt got=%b exp=10", {gnt0, done0});
        end
        req0 = 1'b0;
        step();
        checks++;
        if (done0 !== 1'b1 || sum_out !== 32'd7) begin
            failures++;
            $display("[TB] FAIL abort_redone got=%b/%0d exp=1/7", done0, sum_out);
        end
        step();
    endtask

    task automatic test_latch();
        req0 = 1'b1; a0 = 32'd9; b0 = 32'd1; cin0 = 1'b1;
        step();
        a0 = 32'd1000; b0 = 32'd2000; cin0 = 1'b0; req0 = 1'b0;
        step();
        checks++;
        if (done0 !== 1'b1 || sum_out !== 32'd11) begin
            failures++;
            $display("[TB] FAIL latch_sum got=%b/%0d exp=1/11", done0, sum_out);
        end
        step();
    endtask

    task automatic test_ovf();
        req0 = 1'b1; a0 = 32'h7FFFFFFF; b0 = 32'd1; cin0 = 1'b0;
        step();
        req0 = 1'b0;
        step();
        checks++;
        if ({sum_out, cout_out} !== {32'h80000000, 1'b0}) begin
            failures++;
            $display("[TB] FAIL ovf_sum got=%h/%b exp=80000000/0", sum_out, cout_out);
        end
`ifdef ADD_ARB_OVF_EN
        checks++;
        if (ovf_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_flag got=%b exp=1", ovf_out);
        end
`endif
        step();
        checks++;
        if (sum_out !== 32'h80000000) begin
            failures++;
            $display("[TB] FAIL ovf_hold got=%h exp=80000000", sum_out);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear = 1'b1;
        req0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
        req1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_clear_abort();
        test_latch();
        test_ovf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
